// File: rtl/obstacle_gen.sv
// Obstacle slot manager: spawns at the right edge, scrolls left per frame tick, retires off the left edge.
// Optional speed ramp with retirements is enabled by defining OBSTACLE_SPEEDUP_EN.
module obstacle_gen #(
    parameter int unsigned N_OBS          = 6,
    parameter int unsigned SPAWN_X        = 640,
    parameter int unsigned PARK_X         = 700,
    parameter int unsigned SPEED          = 4,
    parameter int unsigned SPAWN_INTERVAL = 60,
    parameter int unsigned UPPER_BOUND    = 20,
    parameter int unsigned Y_RANGE        = 400,
    parameter int unsigned MAX_SPEED      = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_tick,
    input  logic [1:0]            gamemode,
    output logic [N_OBS*10-1:0]   obstacle_x,
    output logic [N_OBS*9-1:0]    obstacle_y,
    output logic [N_OBS-1:0]      active,
    output logic [15:0]           passed_cnt
);

    localparam int unsigned XW = 10;
    localparam int unsigned YW = 9;
    localparam int unsigned LW = 9;
    localparam int unsigned PW = 16;
    localparam int unsigned CW = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
    localparam int unsigned SW = $clog2(MAX_SPEED + 1);
    localparam logic [LW-1:0] LFSR_SEED = 9'h1A5;

    typedef enum logic [1:0] {
        GM_INIT  = 2'b00,
        GM_RUN   = 2'b01,
        GM_PAUSE = 2'b10,
        GM_END   = 2'b11
    } gamemode_e;

    gamemode_e gm;
    assign gm = gamemode_e'(gamemode);

    logic [XW-1:0] x_q [N_OBS];
    logic [XW-1:0] x_d [N_OBS];
    logic [YW-1:0] y_q [N_OBS];
    logic [YW-1:0] y_d [N_OBS];
    logic [N_OBS-1:0] active_q, active_d;
    logic [PW-1:0] passed_q, passed_d;
    logic [CW-1:0] spawn_cnt_q, spawn_cnt_d;
    logic [LW-1:0] lfsr_q, lfsr_d;
    logic [SW-1:0] speed;

`ifdef OBSTACLE_SPEEDUP_EN
    logic [SW-1:0] speed_q, speed_d;
    assign speed = speed_q;
`else
    assign speed = SW'(SPEED);
`endif

    logic [PW:0]      retire_cnt;
    logic [PW:0]      passed_sum;
    logic [N_OBS-1:0] free_sel;
    logic             free_found;
    logic [LW-1:0]    rnd;

    // Lowest-index free slot in the pre-tick mask
    always_comb begin
        free_sel   = '0;
        free_found = 1'b0;
        for (int k = 0; k < int'(N_OBS); k++) begin
            if (!active_q[k] && !free_found) begin
                free_sel[k] = 1'b1;
                free_found  = 1'b1;
            end
        end
    end

    // Fold the 9-bit LFSR value into the legal y span
    assign rnd = (lfsr_q < LW'(Y_RANGE)) ? lfsr_q : lfsr_q - LW'(Y_RANGE);

    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        active_d    = active_q;
        passed_d    = passed_q;
        spawn_cnt_d = spawn_cnt_q;
        lfsr_d      = {lfsr_q[LW-2:0], lfsr_q[8] ^ lfsr_q[4]};
        retire_cnt  = '0;
        passed_sum  = '0;
`ifdef OBSTACLE_SPEEDUP_EN
        speed_d     = speed_q;
`endif
        case (gm)
            GM_INIT: begin
                for (int k = 0; k < int'(N_OBS); k++) begin
                    x_d[k] = XW'(PARK_X);
                    y_d[k] = '0;
                end
                active_d    = '0;
                passed_d    = '0;
                spawn_cnt_d = '0;
`ifdef OBSTACLE_SPEEDUP_EN
                speed_d     = SW'(SPEED);
`endif
            end
            GM_RUN: begin
                if (frame_tick) begin
                    for (int k = 0; k < int'(N_OBS); k++) begin
                        if (active_q[k]) begin
                            if (x_q[k] >= XW'(speed)) begin
                                x_d[k] = x_q[k] - XW'(speed);
                            end else begin
                                active_d[k] = 1'b0;
                                x_d[k]      = XW'(PARK_X);
                                y_d[k]      = '0;
                                retire_cnt  = retire_cnt + 17'(1);
                            end
                        end
                    end
                    passed_sum = {1'b0, passed_q} + retire_cnt;
                    passed_d   = passed_sum[PW] ? '1 : passed_sum[PW-1:0];

                    // Spawn only into slots free before this tick; otherwise keep retrying
                    if (spawn_cnt_q == CW'(SPAWN_INTERVAL - 1)) begin
                        if (free_found) begin
                            for (int k = 0; k < int'(N_OBS); k++) begin
                                if (free_sel[k]) begin
                                    x_d[k]      = XW'(SPAWN_X);
                                    y_d[k]      = YW'(UPPER_BOUND) + rnd;
                                    active_d[k] = 1'b1;
                                end
                            end
                            spawn_cnt_d = '0;
                        end
                    end else begin
                        spawn_cnt_d = spawn_cnt_q + CW'(1);
                    end
`ifdef OBSTACLE_SPEEDUP_EN
                    if ((passed_d[PW-1:3] != passed_q[PW-1:3]) && (speed_q < SW'(MAX_SPEED))) begin
                        speed_d = speed_q + SW'(1);
                    end
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(N_OBS); k++) begin
                x_q[k] <= XW'(PARK_X);
                y_q[k] <= '0;
            end
            active_q    <= '0;
            passed_q    <= '0;
            spawn_cnt_q <= '0;
            lfsr_q      <= LFSR_SEED;
`ifdef OBSTACLE_SPEEDUP_EN
            speed_q     <= SW'(SPEED);
`endif
        end else begin
            for (int k = 0; k < int'(N_OBS); k++) begin
                x_q[k] <= x_d[k];
                y_q[k] <= y_d[k];
            end
            active_q    <= active_d;
            passed_q    <= passed_d;
            spawn_cnt_q <= spawn_cnt_d;
            lfsr_q      <= lfsr_d;
`ifdef OBSTACLE_SPEEDUP_EN
            speed_q     <= speed_d;
`endif
        end
    end

    for (genvar g = 0; g < int'(N_OBS); g++) begin : g_pack
        assign obstacle_x[g*XW +: XW] = x_q[g];
        assign obstacle_y[g*YW +: YW] = y_q[g];
    end

    assign active     = active_q;
    assign passed_cnt = passed_q;

endmodule
